// File: rtl/me_addr_seq_pkg.sv
// Shared constants, width helper and state type for the motion-estimation
// address sequencer.
package me_pkg;

   localparam int TB_W_DEF = 8;
   localparam int SW_W_DEF = 32;
   localparam int STEP_DEF = 1;

   // Bit width needed to index n items, never less than one bit.
   function automatic int width_of(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/me_addr_seq_wrap_cnt.sv
// Wrapping counter with synchronous clear and enable. It exposes a
// terminal-count flag and a wrap flag (enabled at terminal count), so that
// several instances can be chained into a nested loop.
module me_wrap_cnt #(
   parameter int W  = 3,
   parameter int TC = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         at_tc,
   output logic         wrap
);

   localparam logic [W-1:0] TC_V = W'(TC);

   logic [W-1:0] count_r;

   assign count = count_r;
   assign at_tc = (count_r == TC_V);
   assign wrap  = en & at_tc;

   // Count up on enable, return to zero after the terminal value, clear on demand.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= at_tc ? '0 : count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/me_addr_seq.sv
// Full-search address sequencer: for every candidate displacement it walks
// the template block and emits search-window / template addresses on a
// valid/ready handshake, with candidate coordinates and end markers.
module me_addr_seq
   import me_pkg::*;
#(
   parameter int TB_W = TB_W_DEF,
   parameter int SW_W = SW_W_DEF,
   parameter int STEP = STEP_DEF,
   localparam int N_CAND = (SW_W - TB_W) / STEP + 1,
   localparam int AW_SW  = width_of(SW_W * SW_W),
   localparam int AW_TB  = width_of(TB_W * TB_W),
   localparam int CW     = width_of(N_CAND)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             ready,
   output logic             valid,
   output logic [AW_SW-1:0] addr_sw,
   output logic [AW_TB-1:0] addr_tb,
   output logic [CW-1:0]    cand_x,
   output logic [CW-1:0]    cand_y,
   output logic             last_pix,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int TXW = width_of(TB_W);

   // Address increments: next row inside the block, next candidate along x,
   // next candidate row.
   localparam logic [AW_SW-1:0] ROW_STEP      = AW_SW'(SW_W);
   localparam logic [AW_SW-1:0] CAND_X_STEP   = AW_SW'(STEP);
   localparam logic [AW_SW-1:0] CAND_ROW_STEP = AW_SW'(STEP * SW_W);

   state_t           state_r;
   logic             valid_r;
   logic             busy_r;
   logic             done_r;
   logic [AW_SW-1:0] cand_base_r;
   logic [AW_SW-1:0] cand_row_r;
   logic [AW_SW-1:0] row_base_r;

   logic [TXW-1:0]   tx_s;
   logic [TXW-1:0]   ty_s;
   logic [CW-1:0]    cx_s;
   logic [CW-1:0]    cy_s;
   logic             tx_at_s, ty_at_s, cx_at_s, cy_at_s;
   logic             tx_wrap_s, ty_wrap_s, cx_wrap_s, cy_wrap_s;
   logic             accept_s;
   logic             last_pix_s;
   logic             last_s;

   // Abort outranks a handshake in the same cycle.
   assign accept_s   = valid_r & ready & ~abort;
   assign last_pix_s = tx_at_s & ty_at_s;
   assign last_s     = last_pix_s & cx_at_s & cy_at_s;

   me_wrap_cnt #(.W(TXW), .TC(TB_W - 1)) u_tx (
      .clk(clk), .rst_n(rst_n), .clr(abort), .en(accept_s),
      .count(tx_s), .at_tc(tx_at_s), .wrap(tx_wrap_s));

   me_wrap_cnt #(.W(TXW), .TC(TB_W - 1)) u_ty (
      .clk(clk), .rst_n(rst_n), .clr(abort), .en(tx_wrap_s),
      .count(ty_s), .at_tc(ty_at_s), .wrap(ty_wrap_s));

   me_wrap_cnt #(.W(CW), .TC(N_CAND - 1)) u_cx (
      .clk(clk), .rst_n(rst_n), .clr(abort), .en(ty_wrap_s),
      .count(cx_s), .at_tc(cx_at_s), .wrap(cx_wrap_s));

   me_wrap_cnt #(.W(CW), .TC(N_CAND - 1)) u_cy (
      .clk(clk), .rst_n(rst_n), .clr(abort), .en(cx_wrap_s),
      .count(cy_s), .at_tc(cy_at_s), .wrap(cy_wrap_s));

   // All address terms are flops; the sum avoids any multiplier.
   assign addr_sw  = cand_base_r + row_base_r + AW_SW'(tx_s);
   assign addr_tb  = AW_TB'({ty_s, tx_s});
   assign cand_x   = cx_s;
   assign cand_y   = cy_s;
   assign last_pix = last_pix_s;
   assign last     = last_s;
   assign valid    = valid_r;
   assign busy     = busy_r;
   assign done     = done_r;

   // Control FSM and incremental address base registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cand_base_r <= '0;
         cand_row_r  <= '0;
         row_base_r  <= '0;
      end else if (abort) begin
         state_r     <= ST_IDLE;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cand_base_r <= '0;
         cand_row_r  <= '0;
         row_base_r  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r <= ST_RUN;
                  valid_r <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  if (tx_wrap_s) begin
                     if (ty_wrap_s) begin
                        row_base_r <= '0;
                        if (cy_wrap_s) begin
                           cand_row_r  <= '0;
                           cand_base_r <= '0;
                        end else if (cx_wrap_s) begin
                           cand_row_r  <= cand_row_r + CAND_ROW_STEP;
                           cand_base_r <= cand_row_r + CAND_ROW_STEP;
                        end else begin
                           cand_base_r <= cand_base_r + CAND_X_STEP;
                        end
                     end else begin
                        row_base_r <= row_base_r + ROW_STEP;
                     end
                  end
                  if (last_s) begin
                     state_r <= ST_DONE;
                     valid_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_me_addr_seq.sv
// Self-checking bench: a default instance (8/32/1) and a small instance
// (2/4/2), both checked beat by beat against an arithmetic reference.
module tb_me_addr_seq;

   logic clk = 1'b0;
   logic rst_n, start, abort, ready, sel;

   always #5 clk = ~clk;

   logic       v0, lp0, l0, b0, d0;
   logic [9:0] sw0;
   logic [5:0] tb0;
   logic [4:0] cx0, cy0;
   logic       v1, lp1, l1, b1, d1;
   logic [3:0] sw1;
   logic [1:0] tb1;
   logic [0:0] cx1, cy1;

   me_addr_seq u0 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort && !sel),
      .ready(ready), .valid(v0), .addr_sw(sw0), .addr_tb(tb0),
      .cand_x(cx0), .cand_y(cy0), .last_pix(lp0), .last(l0),
      .busy(b0), .done(d0));

   me_addr_seq #(.TB_W(2), .SW_W(4), .STEP(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort && sel),
      .ready(ready), .valid(v1), .addr_sw(sw1), .addr_tb(tb1),
      .cand_x(cx1), .cand_y(cy1), .last_pix(lp1), .last(l1),
      .busy(b1), .done(d1));

   int o_v, o_sw, o_tb, o_cx, o_cy, o_lp, o_l, o_b, o_d;

   always_comb begin
      if (sel) begin
         o_v = int'(v1); o_sw = int'(sw1); o_tb = int'(tb1); o_cx = int'(cx1);
         o_cy = int'(cy1); o_lp = int'(lp1); o_l = int'(l1); o_b = int'(b1); o_d = int'(d1);
      end else begin
         o_v = int'(v0); o_sw = int'(sw0); o_tb = int'(tb0); o_cx = int'(cx0);
         o_cy = int'(cy0); o_lp = int'(lp0); o_l = int'(l0); o_b = int'(b0); o_d = int'(d0);
      end
   end

   int checks = 0;
   int errors = 0;
   int T, W, S, N;
   int small_sw[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: beat k of a full search, decoded as nested loop indices.
   function automatic void beat(input int k, output int sw, output int tb,
                                output int cx, output int cy, output int lp, output int l);
      int tx, ty;
      tx = k % T;
      ty = (k / T) % T;
      cx = (k / (T * T)) % N;
      cy = k / (T * T * N);
      sw = (cy * S + ty) * W + cx * S + tx;
      tb = ty * T + tx;
      lp = (tx == T - 1 && ty == T - 1) ? 1 : 0;
      l  = (lp == 1 && cx == N - 1 && cy == N - 1) ? 1 : 0;
   endfunction

   task automatic chk_idle(input string p);
      chk({p, "_valid"}, o_v, 0);
      chk({p, "_busy"}, o_b, 0);
      chk({p, "_done"}, o_d, 0);
      chk({p, "_sw"}, o_sw, 0);
      chk({p, "_tb"}, o_tb, 0);
      chk({p, "_cx"}, o_cx, 0);
      chk({p, "_cy"}, o_cy, 0);
      chk({p, "_lp"}, o_lp, 0);
      chk({p, "_last"}, o_l, 0);
   endtask

   // One search: start, present/accept beats, optional start pulse or abort.
   task automatic run(input int rdy_pct, input int start_at, input int abort_at);
      int k = 0, cyc = 0, acc = 0, total, budget;
      int e_sw, e_tb, e_cx, e_cy, e_lp, e_l;
      bit aborted = 1'b0, fin = 1'b0;
      total  = N * N * T * T;
      budget = 4 * total + 100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!fin && !aborted) begin
         if (cyc > budget) begin
            chk("timeout", cyc, budget);
            break;
         end
         beat(k, e_sw, e_tb, e_cx, e_cy, e_lp, e_l);
         chk("valid", o_v, 1);
         chk("busy", o_b, 1);
         chk("done_run", o_d, 0);
         chk("sw", o_sw, e_sw);
         chk("tb", o_tb, e_tb);
         chk("cx", o_cx, e_cx);
         chk("cy", o_cy, e_cy);
         chk("last_pix", o_lp, e_lp);
         chk("last", o_l, e_l);
         if (!sel) begin
            if (k == 0) chk("b0_sw", o_sw, 0);
            if (k == 63) begin
               chk("b63_sw", o_sw, 231); chk("b63_tb", o_tb, 63); chk("b63_lp", o_lp, 1);
            end
            if (k == 64) begin
               chk("b64_sw", o_sw, 1); chk("b64_cx", o_cx, 1); chk("b64_cy", o_cy, 0);
            end
            if (k == 39999) begin
               chk("fin_sw", o_sw, 1023); chk("fin_tb", o_tb, 63);
               chk("fin_cx", o_cx, 24); chk("fin_cy", o_cy, 24); chk("fin_last", o_l, 1);
            end
         end else if (k < 16) begin
            chk("small_sw", o_sw, small_sw[k]);
         end
         start = (k == start_at);
         abort = (k == abort_at);
         ready = abort || (int'($urandom_range(99)) < rdy_pct);
         if (abort) begin
            aborted = 1'b1;
         end else if (ready) begin
            if (o_v == 1) acc++;
            k++;
            if (k == total) fin = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b0;
      if (aborted) begin
         chk_idle("ab");
         repeat (3) begin
            @(negedge clk);
            chk("ab_nodone", o_d, 0);
            chk("ab_novalid", o_v, 0);
         end
      end else if (fin) begin
         chk("acc_cnt", acc, total);
         if (!sel) chk("acc_40000", acc, 40000);
         chk("dn_valid", o_v, 0);
         chk("dn_done", o_d, 1);
         chk("dn_busy", o_b, 0);
         @(negedge clk);
         chk("dn_pulse", o_d, 0);
         chk("dn_idle", o_v, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; sel = 1'b0;
      T = 8; W = 32; S = 1; N = 25;
      repeat (2) @(negedge clk);
      chk_idle("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_rst");

      // start together with abort in IDLE: must stay idle
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk_idle("sa");
      @(negedge clk);
      chk("sa_valid2", o_v, 0);

      run(100, 100, -1);   // full search, stray start at beat 100
      run(50, -1, 1500);   // random ready, then abort
      run(100, -1, 63);    // abort on the sw=231 beat
      run(100, -1, 5);     // restart after abort begins at sw=0

      // asynchronous reset mid-search, off the clock edge
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; ready = 1'b1;
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_idle("arst");
      ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(100, -1, 5);

      sel = 1'b1; T = 2; W = 4; S = 2; N = 2;
      @(negedge clk);
      run(100, -1, -1);
      repeat (4) run(50, -1, -1);
      run(50, 3, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
